// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants: forwarding select encodings and control-bundle bit positions.
// No logic; imported by the ID/EX stage and its operand muxes.
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 7;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand bypass mux: picks regfile, EX result or MEM data by forwarding select.
// Combinational, zero latency; no flow control.
// The reserved select 2'b11 falls back to the regfile value.
module operand_fwd_mux
    import riscv_pipe_pkg::*;
#(
    parameter int WORD_BITWIDTH = 32
) (
    input  logic [1:0]               sel,
    input  logic [WORD_BITWIDTH-1:0] reg_data,
    input  logic [WORD_BITWIDTH-1:0] ex_data,
    input  logic [WORD_BITWIDTH-1:0] mem_data,
    output logic [WORD_BITWIDTH-1:0] data
);

    always_comb begin
        data = reg_data;
        case (sel)
            FWD_EX:  data = ex_data;
            FWD_MEM: data = mem_data;
            default: data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use hazard detection and stall counter.
// Latency: one cycle ID -> EX. Backpressure: stall holds IF/ID and inserts a bubble.
// A flush overrides a hazard, so a killed instruction never stalls the front end.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH   = 5,
    parameter int WORD_BITWIDTH      = 32,
    parameter int CTRL_BITWIDTH      = 8,
    parameter int STALL_CNT_BITWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [WORD_BITWIDTH-1:0]      id_pc,
    input  logic [REG_NUM_BITWIDTH-1:0]   id_Rs1,
    input  logic [REG_NUM_BITWIDTH-1:0]   id_Rs2,
    input  logic [REG_NUM_BITWIDTH-1:0]   id_Rd,
    input  logic [WORD_BITWIDTH-1:0]      id_rs1Data,
    input  logic [WORD_BITWIDTH-1:0]      id_rs2Data,
    input  logic [WORD_BITWIDTH-1:0]      id_imm,
    input  logic [CTRL_BITWIDTH-1:0]      id_ctrl,
    input  logic [1:0]                    forwardA,
    input  logic [1:0]                    forwardB,
    input  logic [WORD_BITWIDTH-1:0]      ex_fwdData,
    input  logic [WORD_BITWIDTH-1:0]      mem_fwdData,
    input  logic                          flush,
    output logic                          ex_valid,
    output logic [WORD_BITWIDTH-1:0]      ex_pc,
    output logic [REG_NUM_BITWIDTH-1:0]   ex_Rs1,
    output logic [REG_NUM_BITWIDTH-1:0]   ex_Rs2,
    output logic [REG_NUM_BITWIDTH-1:0]   ex_Rd,
    output logic [WORD_BITWIDTH-1:0]      ex_opA,
    output logic [WORD_BITWIDTH-1:0]      ex_opB,
    output logic [WORD_BITWIDTH-1:0]      ex_imm,
    output logic [CTRL_BITWIDTH-1:0]      ex_ctrl,
    output logic                          ex_regWrite,
    output logic                          ex_memRead,
    output logic                          stall,
    output logic [STALL_CNT_BITWIDTH-1:0] stall_count
);

    logic [WORD_BITWIDTH-1:0] op_a_next;
    logic [WORD_BITWIDTH-1:0] op_b_next;
    logic                     rd_match;
    logic                     hazard;
    logic                     bubble;

    operand_fwd_mux #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_fwd_a (
        .sel      (forwardA),
        .reg_data (id_rs1Data),
        .ex_data  (ex_fwdData),
        .mem_data (mem_fwdData),
        .data     (op_a_next)
    );

    operand_fwd_mux #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_fwd_b (
        .sel      (forwardB),
        .reg_data (id_rs2Data),
        .ex_data  (ex_fwdData),
        .mem_data (mem_fwdData),
        .data     (op_b_next)
    );

    assign ex_regWrite = ex_ctrl[CTRL_REGWRITE];
    assign ex_memRead  = ex_ctrl[CTRL_MEMREAD];

    // rs fields are compared unconditionally; a false stall on an unused field is harmless.
    assign rd_match = (ex_Rd != '0) && ((ex_Rd == id_Rs1) || (ex_Rd == id_Rs2));
    assign hazard   = ex_valid && ex_memRead && id_valid && !flush && rd_match;
    assign stall    = hazard;
    assign bubble   = flush || hazard;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_Rs1   <= '0;
            ex_Rs2   <= '0;
            ex_Rd    <= '0;
            ex_opA   <= '0;
            ex_opB   <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_Rs1   <= id_Rs1;
            ex_Rs2   <= id_Rs2;
            ex_Rd    <= id_Rd;
            ex_opA   <= op_a_next;
            ex_opB   <= op_b_next;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core. It consumes the forwardA/forwardB selects produced by the forwarding unit in ID.
- Applies the operand bypass muxes and latches the resolved operands, immediate and control bundle into EX.
- Detects load-use hazards against the instruction it currently holds; on a hit it stalls IF/ID and inserts a bubble.
- Handles branch flush and keeps a saturating stall counter for performance debug.

Parameters:
- REG_NUM_BITWIDTH, 5, register index width.
- WORD_BITWIDTH, 32, data/PC width.
- CTRL_BITWIDTH, 8, control bundle width. Layout is defined in the package.
- STALL_CNT_BITWIDTH, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  WORD_BITWIDTH  PC of the ID instruction.
- id_Rs1, id_Rs2, id_Rd  in  REG_NUM_BITWIDTH each  register indices.
- id_rs1Data, id_rs2Data  in  WORD_BITWIDTH each  register file read data.
- id_imm  in  WORD_BITWIDTH  decoded immediate.
- id_ctrl  in  CTRL_BITWIDTH  decoded control bundle.
- forwardA, forwardB  in  2 each  forwarding selects. 00 = regfile, 10 = EX result, 01 = MEM data, 11 = reserved and treated as 00.
- ex_fwdData  in  WORD_BITWIDTH  ALU result of the instruction now in EX.
- mem_fwdData  in  WORD_BITWIDTH  writeback-candidate data of the instruction now in MEM.
- flush  in  1  kill the ID instruction (taken branch/jump resolved in EX).
- ex_valid  out  1  registered.
- ex_pc  out  WORD_BITWIDTH  registered.
- ex_Rs1, ex_Rs2, ex_Rd  out  REG_NUM_BITWIDTH each  registered.
- ex_opA, ex_opB  out  WORD_BITWIDTH each  registered forwarded operands.
- ex_imm  out  WORD_BITWIDTH  registered.
- ex_ctrl  out  CTRL_BITWIDTH  registered.
- ex_regWrite, ex_memRead  out  1 each  decoded from ex_ctrl, combinational from registered state.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- stall_count  out  STALL_CNT_BITWIDTH  registered, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: every registered output is 0. This gives ex_valid=0, ex_ctrl=0, ex_regWrite=0, ex_memRead=0, stall_count=0, and stall=0.
- Operand mux (combinational, before the register):
  - opA_next: id_rs1Data when forwardA=00 or 11; ex_fwdData when 10; mem_fwdData when 01.
  - opB_next: same rule using forwardB and id_rs2Data.
- Hazard condition:
  - hazard = ex_valid & ex_memRead & id_valid & ~flush & ex_Rd≠0 & (ex_Rd==id_Rs1 | ex_Rd==id_Rs2).
  - stall = hazard.
  - No rs-usage qualification: a false stall on an unused rs field is accepted.
- Per-cycle update at the clock edge, highest priority first:
  1. rst: clear all registers.
  2. flush: insert a bubble (ex_valid=0, ex_ctrl=0, ex_Rd=0; other fields don't-care but cleared to 0). stall is 0 because flush masks hazard.
  3. hazard: insert a bubble as above. IF/ID holds because stall=1. Next cycle the load is in MEM, the forwarding unit issues 01, and the re-presented ID instruction latches normally.
  4. Otherwise: latch ex_valid=id_valid and all id_* fields, with ex_opA=opA_next and ex_opB=opB_next. If id_valid=0, ex_ctrl is forced to 0.
- Latency: one cycle from ID to EX outputs.
- Load-use bubble: exactly one cycle per load-use pair. Back-to-back loads that each feed the next stall once per pair.
- stall_count: increments by 1 on each clock edge where stall=1 and rst=0. It saturates at all-ones with no wrap and is cleared only by rst.
- Reset mid-stall: the next edge clears the register, so stall drops combinationally after that edge. No stale bubble state is retained.
- Simultaneous flush and hazard: flush wins, the bubble is inserted, and stall_count is not incremented.

Decomposition:
- Package riscv_pipe_pkg holds:
  - forwarding select constants FWD_REG=2'b00, FWD_MEM=2'b01, FWD_EX=2'b10;
  - ctrl bit indices CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_BRANCH=3, CTRL_JUMP=4, CTRL_ALUSRC=5, CTRL_ALUOP=7:6.
- One sub-module: operand_fwd_mux (2-bit select to a word), instantiated twice.
- Hazard logic and registers stay in the top module.

Test Plan:
1. Reset: assert rst for 2 cycles while driving id_valid=1 and id_ctrl=8'h03 -> all outputs 0 after the edge, stall_count=0.
2. Forwarding: id_rs1Data=0x11, ex_fwdData=0x22, mem_fwdData=0x33.
   - forwardA=10, forwardB=01 -> ex_opA=0x22, ex_opB=0x33 next cycle.
   - forwardA=11 -> ex_opA=0x11.
3. Load-use: lw x5 in ID/EX (ex_memRead=1, ex_Rd=5), ID presents add with id_Rs2=5 -> stall=1 for one cycle and ex_valid=0 next edge; stall_count=1. The following cycle, with forwardB=01 and mem_fwdData=0xABCD, latches ex_opB=0xABCD.
4. x0 immunity: load with ex_Rd=0 and id_Rs1=0 -> stall=0, no bubble.
5. Flush priority: hazard condition true and flush=1 -> stall=0, bubble inserted, stall_count unchanged.
6. Saturation: with STALL_CNT_BITWIDTH=4, force 20 stall cycles -> stall_count holds at 4'hF.
